// File: rtl/dcache.sv
// dcache: direct-mapped, write-back data cache, 8 lines x 4 bytes.
//
// Sits between the CPU byte-wide data port and a block-wide data memory.
// Hits are served combinationally with no stall. A miss stalls the CPU via
// BUSYWAIT. A dirty victim is written back first, then the line is refilled
// from memory and the access completes on the following IDLE cycle.
//
// Ports
//   CLK            system clock, all state changes on posedge
//   RESET          asynchronous active-low reset
//   READ/WRITE     CPU load/store request, held until BUSYWAIT is low
//   ADDRESS        CPU byte address: tag[7:5] index[4:2] offset[1:0]
//   WRITEDATA      CPU store byte
//   READDATA       load byte, valid when READ=1 and BUSYWAIT=0
//   BUSYWAIT       stall to the CPU
//   MEM_READ       block fetch request (registered)
//   MEM_WRITE      block write-back request (registered)
//   MEM_ADDRESS    block address {tag,index} (registered)
//   MEM_WRITEDATA  victim block, byte0 in [7:0] (registered)
//   MEM_READDATA   fetched block, byte0 in [7:0]
//   MEM_BUSYWAIT   memory busy
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [7:0]  valid_r;
  logic [7:0]  dirty_r;
  logic [2:0]  tag_r  [8];
  logic [31:0] data_r [8];
  logic [31:0] fill_r;

  logic        mem_read_r;
  logic        mem_write_r;
  logic [5:0]  mem_address_r;
  logic [31:0] mem_writedata_r;

  logic        mem_read_next_s;
  logic        mem_write_next_s;
  logic [5:0]  mem_address_next_s;
  logic [31:0] mem_writedata_next_s;

  logic [2:0]  addr_tag_s;
  logic [2:0]  index_s;
  logic [1:0]  offset_s;
  logic        request_s;
  logic        hit_s;
  logic        busy_s;

  // Pick one byte out of a block.
  function automatic logic [7:0] byte_sel(input logic [31:0] blk, input logic [1:0] off);
    case (off)
      2'd0:    byte_sel = blk[7:0];
      2'd1:    byte_sel = blk[15:8];
      2'd2:    byte_sel = blk[23:16];
      2'd3:    byte_sel = blk[31:24];
      default: byte_sel = 8'h00;
    endcase
  endfunction

  // Replace one byte of a block, leaving the other three intact.
  function automatic logic [31:0] byte_merge(input logic [31:0] blk, input logic [1:0] off,
                                             input logic [7:0] b);
    byte_merge = blk;
    case (off)
      2'd0:    byte_merge[7:0]   = b;
      2'd1:    byte_merge[15:8]  = b;
      2'd2:    byte_merge[23:16] = b;
      2'd3:    byte_merge[31:24] = b;
      default: byte_merge = blk;
    endcase
  endfunction

  assign addr_tag_s = ADDRESS[7:5];
  assign index_s    = ADDRESS[4:2];
  assign offset_s   = ADDRESS[1:0];
  assign request_s  = READ | WRITE;
  assign hit_s      = valid_r[index_s] && (tag_r[index_s] == addr_tag_s);

  // Reset is gated in so the CPU sees no stall and no data while reset is held.
  assign BUSYWAIT = RESET & busy_s;
  assign READDATA = (RESET && (state_r == IDLE) && READ && hit_s) ?
                    byte_sel(data_r[index_s], offset_s) : 8'h00;

  assign MEM_READ      = mem_read_r;
  assign MEM_WRITE     = mem_write_r;
  assign MEM_ADDRESS   = mem_address_r;
  assign MEM_WRITEDATA = mem_writedata_r;

  // Next-state, CPU stall and next memory-port values.
  always_comb begin
    state_next_s         = state_r;
    busy_s               = 1'b1;
    mem_read_next_s      = 1'b0;
    mem_write_next_s     = 1'b0;
    mem_address_next_s   = 6'd0;
    mem_writedata_next_s = 32'd0;

    case (state_r)
      IDLE: begin
        busy_s = request_s & ~hit_s;
        if (request_s && !hit_s) begin
          if (valid_r[index_s] && dirty_r[index_s]) begin
            state_next_s = WRITEBACK;
          end else begin
            state_next_s = FETCH;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (!MEM_BUSYWAIT) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = WRITEBACK;
        end
      end
      FETCH: begin
        if (!MEM_BUSYWAIT) begin
          state_next_s = UPDATE;
        end else begin
          state_next_s = FETCH;
        end
      end
      UPDATE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // Memory-port values follow the state being entered, so they are
    // registered alongside the state and stay constant for the whole request
    // (tag and data of the victim cannot change while it is written back).
    case (state_next_s)
      WRITEBACK: begin
        mem_write_next_s     = 1'b1;
        mem_address_next_s   = {tag_r[index_s], index_s};
        mem_writedata_next_s = data_r[index_s];
      end
      FETCH: begin
        mem_read_next_s    = 1'b1;
        mem_address_next_s = ADDRESS[7:2];
      end
      default: begin
        mem_read_next_s      = 1'b0;
        mem_write_next_s     = 1'b0;
        mem_address_next_s   = 6'd0;
        mem_writedata_next_s = 32'd0;
      end
    endcase
  end

  // State register and registered memory-port outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r         <= IDLE;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= 6'd0;
      mem_writedata_r <= 32'd0;
    end else begin
      state_r         <= state_next_s;
      mem_read_r      <= mem_read_next_s;
      mem_write_r     <= mem_write_next_s;
      mem_address_r   <= mem_address_next_s;
      mem_writedata_r <= mem_writedata_next_s;
    end
  end

  // Capture the fetched block on the edge that ends the fetch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fill_r <= 32'd0;
    end else if ((state_r == FETCH) && !MEM_BUSYWAIT) begin
      fill_r <= MEM_READDATA;
    end
  end

  // Line arrays: refill in UPDATE, byte store on an IDLE write hit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_r <= 8'd0;
      dirty_r <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tag_r[i]  <= 3'd0;
        data_r[i] <= 32'd0;
      end
    end else if (state_r == UPDATE) begin
      data_r[index_s]  <= fill_r;
      tag_r[index_s]   <= addr_tag_s;
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if ((state_r == IDLE) && WRITE && hit_s) begin
      data_r[index_s]  <= byte_merge(data_r[index_s], offset_s, WRITEDATA);
      dirty_r[index_s] <= 1'b1;
    end
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back data cache between the CPU data port and the block-wide data memory. It holds 8 lines of 4 bytes and serves CPU byte loads and stores with zero stall on a hit. On a miss it stalls the CPU through BUSYWAIT, writes back a dirty victim, refills the line from memory and then completes the access. It replaces the direct CPU-to-memory connection in the CPU testbench; the CPU-side ports are unchanged.

## Interface
- none: geometry fixed at 8 lines x 4 bytes; ADDRESS split tag[7:5], index[4:2], offset[1:0]
- CLK  in  1  system clock; all state changes on posedge
- RESET  in  1  asynchronous, active-low reset (asserted when 0)
- READ  in  1  CPU load request, held until BUSYWAIT low
- WRITE  in  1  CPU store request, held until BUSYWAIT low
- ADDRESS  in  8  CPU byte address
- WRITEDATA  in  8  CPU store data
- READDATA  out  8  load data, valid when READ=1 and BUSYWAIT=0
- BUSYWAIT  out  1  stall to CPU
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block write-back request
- MEM_ADDRESS  out  6  block address {tag,index}
- MEM_WRITEDATA  out  32  victim block, byte0 in [7:0]
- MEM_READDATA  in  32  fetched block, byte0 in [7:0]
- MEM_BUSYWAIT  in  1  memory busy

## Operation
- Per line: valid, dirty, tag[2:0], data[31:0]. hit = valid[index] and tag[index]==ADDRESS[7:5].
- If WRITE=1 and READ=1 together, the request is treated as a write.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE, request and hit:
  - BUSYWAIT=0.
  - Read: READDATA = data[index] byte at offset.
  - Write: the byte is written at the next posedge and dirty[index] is set.
- IDLE, request and miss: BUSYWAIT=1 in the same cycle. At the posedge, go to WRITEBACK if the line is valid and dirty, else go to FETCH.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={old tag,index}, MEM_WRITEDATA=data[index]; all held stable.
  - Go to FETCH on the first posedge with MEM_BUSYWAIT=0.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
  - Go to UPDATE on the first posedge with MEM_BUSYWAIT=0; MEM_READDATA is captured at that edge.
- UPDATE:
  - One cycle; MEM_READ and MEM_WRITE are 0.
  - At the posedge: write the block, set tag, valid=1, dirty=0; go to IDLE.
  - The request then hits in IDLE: a read returns data, a write completes and sets dirty.
- BUSYWAIT = 1 in every non-IDLE state; in IDLE it is (READ or WRITE) and not hit.
- No request (READ=WRITE=0): BUSYWAIT=0; the data array is unchanged.
- Memory contract: MEM_BUSYWAIT rises before the first posedge after MEM_READ or MEM_WRITE rises, and falls when the access is done.

## Timing
- Reset (RESET=0, asynchronous):
  - All valid=0 and dirty=0; state=IDLE.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - BUSYWAIT=0 while reset is held.
- Reset mid-operation: the memory transaction is abandoned and MEM_READ/MEM_WRITE drop immediately. All lines are invalidated, so dirty data is lost by design.
- Hit path is combinational with model delays: #1 tag compare and valid, #1 data select. READDATA and BUSYWAIT are settled 2 time units after ADDRESS or READ/WRITE change.
- Array writes and FSM transitions happen at posedge with #1.
- Latency, with M = number of cycles MEM_BUSYWAIT is high:
  - Hit: 0 stall cycles.
  - Clean miss: 1 (IDLE) + M (FETCH) + 1 (UPDATE) stall cycles; the access completes on the following IDLE cycle.
  - Dirty miss: adds M write-back cycles.
- Address, data and request outputs to memory stay stable for the full duration of each memory request.
- The CPU may not change ADDRESS, WRITEDATA, READ or WRITE while BUSYWAIT=1.

## Test plan
- Reset, then load 0x00 → miss; MEM_READ with MEM_ADDRESS=0x00; memory returns 0x44332211; READDATA=0x11 after refill; load 0x03 → hit, 0x44 with 0 stall cycles.
- Store 0xAB to 0x01 (hit, line 0 valid) → no stall; dirty[0]=1; load 0x01 → 0xAB; MEM_READ and MEM_WRITE stay 0.
- Load 0x20 (same index 0, tag 1) with line 0 dirty → WRITEBACK with MEM_ADDRESS=0x00, MEM_WRITEDATA=0x4433AB11; then FETCH with MEM_ADDRESS=0x08; total stall = 2M+2 cycles.
- Clean conflict miss: load 0x40 after the line at 0x20 was refilled clean → no MEM_WRITE; only FETCH of 0x10.
- Assert RESET=0 during FETCH → MEM_READ=0 and BUSYWAIT=0 immediately; after release, load 0x20 misses again.
- Store to 0x1F with no prior access → MEM_READ of block 0x07, then byte 3 written; line 7 dirty=1 and tag=0.
